branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Tracks every prediction the branch predictor makes at fetch, pairs it in order with the outcome resolved in execute, and raises a one-cycle flush with the corrected PC on a mispredict. Also generates the BTB write/invalidate request that trains the predictor. Sits between the fetch stage (push side, alongside the predictor lookup) and the execute stage (resolve side); its update outputs feed the predictor's update port.

## Interface
- DEPTH, 4: in-flight prediction queue entries (power of two, ≥2)
- ADDR_W, 30: word-address width (byte PC[31:2])
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- f_valid  in  1  fetch pushes a prediction record
- f_pc  in  ADDR_W  word PC of fetched instruction
- f_phit  in  1  predictor hit (hit ⇒ predicted taken)
- f_ptarget  in  ADDR_W  predicted target (meaningful when f_phit)
- f_ready  out  1  record accepted this cycle
- e_valid  in  1  execute resolves oldest record (pop)
- e_is_br  in  1  resolved instruction is branch/jump
- e_taken  in  1  actual direction
- e_target  in  ADDR_W  actual target
- flush  out  1  squash fetch/decode, registered
- redirect_pc  out  ADDR_W  PC to refetch, valid with flush
- upd_valid  out  1  predictor update strobe
- upd_inval  out  1  with upd_valid: clear entry instead of write
- upd_pc  out  ADDR_W  PC indexing the update
- upd_target  out  ADDR_W  target to store
- underflow  out  1  sticky: e_valid seen with empty queue
- br_count, mispred_count  out  32  stats (see Configuration)

## Operation
- Queue: circular buffer of {pc, phit, ptarget}; rd/wr pointers log2(DEPTH) bits, wrap mod DEPTH; count 0..DEPTH.
- f_ready = state==RUN && (count<DEPTH || e_valid). Push occurs iff f_valid && f_ready; full + simultaneous pop+push allowed.
- Pop iff e_valid && count>0 && state==RUN. e_valid with empty queue: ignored, underflow set until RST.
- Next-PC arithmetic mod 2^ADDR_W: seq = pc+1 (all-ones wraps to 0).
- predicted_next = phit ? ptarget : seq; actual_next = (e_is_br && e_taken) ? e_target : seq.
- Mispredict iff predicted_next != actual_next.
- Update: write (upd_inval=0, upd_target=e_target) iff e_is_br && e_taken && (!phit || ptarget!=e_target); invalidate (upd_inval=1, upd_target=0) iff phit && !(e_is_br && e_taken). Otherwise no update.
- FSM:
  - RUN: normal push/pop. On mispredict pop → RECOVER; queue cleared (count=0, pointers to 0), any same-cycle push discarded.
  - RECOVER: one cycle; f_ready=0, e_valid ignored (no pop, no underflow); → RUN.

## Timing
- flush, redirect_pc, upd_* registered: asserted exactly the cycle after the resolving pop, for one cycle. flush high coincides with state RECOVER.
- Update and flush can coincide.
- Back-to-back pops: one update per cycle, no bubbles except after mispredict.
- RST in any state: next edge clears queue, state=RUN, flush=0, redirect_pc=0, upd_valid=0, upd_inval=0, upd_pc=0, upd_target=0, underflow=0, counters=0. f_ready=1 in the cycle after reset.

## Configuration
- BR_STATS_EN defined: br_count increments on each pop with e_is_br; mispred_count on each mispredict pop; both saturate at 32'hFFFF_FFFF; registered.
- Undefined: counters not built, br_count and mispred_count tied to 0; ports remain.

## Test plan
- Reset: RST high 2 cycles mid-stream with count=3 → all outputs 0, f_ready=1, next pop with empty queue sets underflow.
- Correct hit: push pc=0x100, phit=1, ptarget=0x200; resolve taken, target 0x200 → no flush, no update, mispred_count=0, br_count=1.
- Miss, taken: push pc=0x40, phit=0; resolve taken, target 0x80 → next cycle flush=1, redirect_pc=0x80, upd_valid=1, upd_pc=0x40, upd_target=0x80; queue empty; f_ready=0 that cycle.
- False hit: push pc=0x10, phit=1, ptarget=0x30; resolve e_is_br=0 → flush, redirect_pc=0x11, upd_inval=1.
- Full/wrap: push 4, f_ready drops with no pop; simultaneous push+pop while full accepted; 10 correct resolves wrap pointers with in-order pairing.
- Wrap arithmetic: pc=0x3FFFFFFF, phit=1, not-taken branch → redirect_pc=0, upd_inval=1.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Pairs fetch-time branch predictions with execute-time outcomes, flushing on mispredict
// and emitting BTB write/invalidate requests. Optional stats counters: define BR_STATS_EN.
module branch_resolve_unit #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic              f_phit,
  input  logic [ADDR_W-1:0] f_ptarget,
  output logic              f_ready,
  input  logic              e_valid,
  input  logic              e_is_br,
  input  logic              e_taken,
  input  logic [ADDR_W-1:0] e_target,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              upd_valid,
  output logic              upd_inval,
  output logic [ADDR_W-1:0] upd_pc,
  output logic [ADDR_W-1:0] upd_target,
  output logic              underflow,
  output logic [31:0]       br_count,
  output logic [31:0]       mispred_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t            state_reg;
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W:0]    count_reg;

  logic [ADDR_W-1:0] pc_mem      [DEPTH];
  logic              phit_mem    [DEPTH];
  logic [ADDR_W-1:0] ptarget_mem [DEPTH];

  logic              do_pop, do_push, push_commit, mispred, taken_br;
  logic              upd_write, upd_clear;
  logic [ADDR_W-1:0] head_pc, head_ptarget, seq_pc, pred_next, actual_next;
  logic              head_phit;

  // Head is read combinationally so a resolve completes in the same cycle it arrives.
  assign head_pc      = pc_mem[rd_ptr_reg];
  assign head_phit    = phit_mem[rd_ptr_reg];
  assign head_ptarget = ptarget_mem[rd_ptr_reg];

  assign seq_pc      = head_pc + ADDR_W'(1);
  assign taken_br    = e_is_br && e_taken;
  assign pred_next   = head_phit ? head_ptarget : seq_pc;
  assign actual_next = taken_br ? e_target : seq_pc;
  assign mispred     = pred_next != actual_next;

  assign upd_write = taken_br && (!head_phit || head_ptarget != e_target);
  assign upd_clear = head_phit && !taken_br;

  assign f_ready     = (state_reg == RUN) && ((count_reg < FULL_CNT) || e_valid);
  assign do_pop      = e_valid && (count_reg != '0) && (state_reg == RUN);
  assign do_push     = f_valid && f_ready;
  assign push_commit = do_push && !(do_pop && mispred);

  always_ff @(posedge CLK) begin
    if (push_commit) begin
      pc_mem[wr_ptr_reg]      <= f_pc;
      phit_mem[wr_ptr_reg]    <= f_phit;
      ptarget_mem[wr_ptr_reg] <= f_ptarget;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= RUN;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      upd_valid   <= 1'b0;
      upd_inval   <= 1'b0;
      upd_pc      <= '0;
      upd_target  <= '0;
      underflow   <= 1'b0;
    end else begin
      flush     <= 1'b0;
      upd_valid <= 1'b0;
      upd_inval <= 1'b0;
      case (state_reg)
        RUN: begin
          if (e_valid && count_reg == '0)
            underflow <= 1'b1;
          if (do_pop && mispred) begin
            state_reg   <= RECOVER;
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            flush       <= 1'b1;
            redirect_pc <= actual_next;
          end else begin
            if (do_pop)
              rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (do_push)
              wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_push && !do_pop)
              count_reg <= count_reg + (PTR_W+1)'(1);
            else if (do_pop && !do_push)
              count_reg <= count_reg - (PTR_W+1)'(1);
          end
          if (do_pop && (upd_write || upd_clear)) begin
            upd_valid  <= 1'b1;
            upd_inval  <= upd_clear;
            upd_pc     <= head_pc;
            upd_target <= upd_clear ? '0 : e_target;
          end
        end
        RECOVER: state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (do_pop) begin
      if (e_is_br && br_count != 32'hFFFF_FFFF)
        br_count <= br_count + 32'd1;
      if (mispred && mispred_count != 32'hFFFF_FFFF)
        mispred_count <= mispred_count + 32'd1;
    end
  end
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized + directed bench for branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 30;

  logic          CLK = 0, RST = 1;
  logic          f_valid = 0, f_phit = 0, e_valid = 0, e_is_br = 0, e_taken = 0;
  logic [AW-1:0] f_pc = '0, f_ptarget = '0, e_target = '0;
  logic          f_ready, flush, upd_valid, upd_inval, underflow;
  logic [AW-1:0] redirect_pc, upd_pc, upd_target;
  logic [31:0]   br_count, mispred_count;

  branch_resolve_unit #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST),
    .f_valid(f_valid), .f_pc(f_pc), .f_phit(f_phit), .f_ptarget(f_ptarget), .f_ready(f_ready),
    .e_valid(e_valid), .e_is_br(e_is_br), .e_taken(e_taken), .e_target(e_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_inval(upd_inval), .upd_pc(upd_pc), .upd_target(upd_target),
    .underflow(underflow), .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] pc;
    logic          phit;
    logic [AW-1:0] pt;
  } rec_t;

  rec_t          mq[$];
  bit            m_recover, m_under, m_flush, m_uv, m_ui;
  logic [AW-1:0] m_rpc, m_upc, m_utg;
  logic [31:0]   m_br, m_mis;
  int            n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_recover = 0; m_under = 0; m_flush = 0; m_uv = 0; m_ui = 0;
    m_rpc = '0; m_upc = '0; m_utg = '0; m_br = 0; m_mis = 0;
  endtask

  // One clock: drive inputs, check f_ready, advance the model, check registered outputs.
  task automatic step(input logic fv, input logic [AW-1:0] pc, input logic ph,
                      input logic [AW-1:0] pt, input logic ev, input logic br,
                      input logic tk, input logic [AW-1:0] tg);
    bit exp_ready, mis;
    rec_t r;
    logic [AW-1:0] seq, pn, an;
    @(negedge CLK);
    f_valid = fv; f_pc = pc; f_phit = ph; f_ptarget = pt;
    e_valid = ev; e_is_br = br; e_taken = tk; e_target = tg;
    #1;
    exp_ready = !m_recover && (mq.size() < DEPTH || ev);
    check("f_ready", {31'd0, f_ready}, {31'd0, exp_ready});
    m_flush = 0; m_uv = 0; m_ui = 0; mis = 0;
    if (m_recover) begin
      m_recover = 0;
    end else begin
      if (ev && mq.size() == 0) m_under = 1;
      if (ev && mq.size() > 0) begin
        r   = mq.pop_front();
        seq = r.pc + 1;
        pn  = r.phit ? r.pt : seq;
        an  = (br && tk) ? tg : seq;
        mis = (pn != an);
        if (br && m_br != 32'hFFFF_FFFF) m_br++;
        if (mis) begin
          m_flush = 1; m_rpc = an; m_recover = 1; mq.delete();
          if (m_mis != 32'hFFFF_FFFF) m_mis++;
        end
        if (br && tk && (!r.phit || r.pt != tg)) begin
          m_uv = 1; m_ui = 0; m_upc = r.pc; m_utg = tg;
        end else if (r.phit && !(br && tk)) begin
          m_uv = 1; m_ui = 1; m_upc = r.pc; m_utg = '0;
        end
      end
      if (fv && exp_ready && !mis) mq.push_back('{pc: pc, phit: ph, pt: pt});
    end
    @(posedge CLK);
    #1;
    check("flush", {31'd0, flush}, {31'd0, m_flush});
    check("upd_valid", {31'd0, upd_valid}, {31'd0, m_uv});
    check("underflow", {31'd0, underflow}, {31'd0, m_under});
    if (m_flush) begin
      check("redirect_pc", {2'd0, redirect_pc}, {2'd0, m_rpc});
      check("f_ready_recover", {31'd0, f_ready}, 32'd0);
    end
    if (m_uv) begin
      check("upd_inval", {31'd0, upd_inval}, {31'd0, m_ui});
      check("upd_pc", {2'd0, upd_pc}, {2'd0, m_upc});
      check("upd_target", {2'd0, upd_target}, {2'd0, m_utg});
    end
`ifdef BR_STATS_EN
    check("br_count", br_count, m_br);
    check("mispred_count", mispred_count, m_mis);
`else
    check("br_count", br_count, 32'd0);
    check("mispred_count", mispred_count, 32'd0);
`endif
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, 0, 0, '0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    RST = 1; f_valid = 0; e_valid = 0;
    repeat (cycles) @(posedge CLK);
    #1;
    model_reset();
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_redirect", {2'd0, redirect_pc}, 32'd0);
    check("rst_upd", {31'd0, upd_valid, upd_inval}, 32'd0);
    check("rst_upd_pc", {2'd0, upd_pc}, 32'd0);
    check("rst_upd_target", {2'd0, upd_target}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
    check("rst_counts", br_count | mispred_count, 32'd0);
    @(negedge CLK);
    RST = 0;
  endtask

  initial begin
    logic [AW-1:0] pc, pt, tg;
    logic fv, ph, ev, br, tk;
    model_reset();
    do_reset(2);

    // Correct hit: no flush, no update
    step(1, 30'h100, 1, 30'h200, 0, 0, 0, '0);
    step(0, '0, 0, '0, 1, 1, 1, 30'h200);
    check("hit_noflush", {31'd0, flush}, 32'd0);
    check("hit_noupd", {31'd0, upd_valid}, 32'd0);

    // Miss, taken
    step(1, 30'h40, 0, '0, 0, 0, 0, '0);
    step(0, '0, 0, '0, 1, 1, 1, 30'h80);
    check("miss_rpc", {2'd0, redirect_pc}, 32'h80);
    check("miss_upc", {2'd0, upd_pc}, 32'h40);
    check("miss_utg", {2'd0, upd_target}, 32'h80);
    idle();

    // False hit on non-branch
    step(1, 30'h10, 1, 30'h30, 0, 0, 0, '0);
    step(0, '0, 0, '0, 1, 0, 0, '0);
    check("falsehit_rpc", {2'd0, redirect_pc}, 32'h11);
    check("falsehit_inval", {31'd0, upd_inval}, 32'd1);
    idle();

    // Fill, overfill attempt, push+pop while full, then 10 in-order resolves
    for (int i = 0; i < 4; i++) step(1, AW'(32'h200 + i), 0, '0, 0, 0, 0, '0);
    step(1, 30'h2FF, 0, '0, 0, 0, 0, '0);
    check("full_ready", {31'd0, f_ready}, 32'd0);
    for (int i = 0; i < 10; i++) step(1, AW'(32'h300 + i), 0, '0, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, '0, 0, '0, 1, 0, 0, '0);

    // PC wrap: not-taken branch at all-ones PC with a stale hit
    step(1, 30'h3FFFFFFF, 1, 30'h5, 0, 0, 0, '0);
    step(0, '0, 0, '0, 1, 1, 0, '0);
    check("wrap_rpc", {2'd0, redirect_pc}, 32'd0);
    check("wrap_inval", {31'd0, upd_inval}, 32'd1);
    idle();

    // Reset mid-stream with three records queued, then pop on empty queue
    for (int i = 0; i < 3; i++) step(1, AW'(32'h500 + i), 0, '0, 0, 0, 0, '0);
    do_reset(2);
    step(0, '0, 0, '0, 1, 1, 1, 30'h9);
    check("underflow_set", {31'd0, underflow}, 32'd1);
    do_reset(1);

    // Randomized traffic, biased so most resolves are correct predictions
    for (int n = 0; n < 800; n++) begin
      fv = ($urandom % 4) != 0;
      pc = ($urandom % 16 == 0) ? 30'h3FFFFFFF : AW'($urandom_range(0, 63));
      ph = $urandom % 2;
      pt = AW'($urandom_range(0, 63));
      ev = ($urandom % 3) != 0;
      br = $urandom % 2;
      tk = $urandom % 2;
      tg = AW'($urandom_range(0, 63));
      if (mq.size() > 0 && ($urandom % 10) < 7) begin
        if (mq[0].phit) begin
          br = 1; tk = 1; tg = mq[0].pt;
        end else begin
          tk = 0;
        end
      end
      step(fv, pc, ph, pt, ev, br, tk, tg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
